// File: rtl/uart_fifo_v3.sv
// Single-clock parametrised FIFO for UART byte buffering, with selectable
// first-word-fall-through reads, threshold flags, occupancy count and sticky error flags.
module uart_fifo_v3 #(
  parameter int DATA_WIDTH    = 8,
  parameter int DEPTH         = 2048,
  parameter int AFULL_THRESH  = DEPTH - 4,
  parameter int AEMPTY_THRESH = 4,
  parameter int FWFT          = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam bit FWFT_MODE = (FWFT != 0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_AF   = CW'(AFULL_THRESH);
  localparam logic [CW-1:0] CNT_AE   = CW'(AEMPTY_THRESH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  mem_rd;
  logic                  rd_valid_next;
  logic [CW-1:0]         mem_count;
  logic [CW-1:0]         count_next;

  // In FWFT mode count includes the output register, so memory holds count minus that word.
  always_comb begin
    wr_acc    = wr_en && !full && !flush;
    rd_acc    = rd_en && !empty && !flush;
    mem_count = count - {{AW{1'b0}}, rd_valid};
    if (FWFT_MODE) begin
      mem_rd = !flush && (!rd_valid || rd_acc) && (mem_count != '0);
    end else begin
      mem_rd = rd_acc;
    end

    rd_valid_next = 1'b0;
    if (flush) begin
      rd_valid_next = 1'b0;
    end else if (FWFT_MODE) begin
      if (mem_rd) begin
        rd_valid_next = 1'b1;
      end else if (rd_acc) begin
        rd_valid_next = 1'b0;
      end else begin
        rd_valid_next = rd_valid;
      end
    end else begin
      rd_valid_next = rd_acc;
    end

    count_next = count;
    if (flush) begin
      count_next = '0;
    end else if (wr_acc && !rd_acc) begin
      count_next = count + CNT_ONE;
    end else if (rd_acc && !wr_acc) begin
      count_next = count - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= din;
    end
  end

  // Flags are derived from the next count so they change on the same edge as the operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      dout         <= '0;
      rd_valid     <= 1'b0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr_acc) begin
          wr_ptr <= wr_ptr + AW'(1);
        end
        if (mem_rd) begin
          rd_ptr <= rd_ptr + AW'(1);
        end
      end
      if (mem_rd) begin
        dout <= mem[rd_ptr];
      end
      rd_valid     <= rd_valid_next;
      count        <= count_next;
      full         <= (count_next == CNT_FULL);
      empty        <= FWFT_MODE ? !rd_valid_next : (count_next == '0);
      almost_full  <= (count_next >= CNT_AF);
      almost_empty <= (count_next <= CNT_AE);

      if (wr_en && full && !flush) begin
        overflow <= 1'b1;
      end else if (clr_err) begin
        overflow <= 1'b0;
      end
      if (rd_en && empty && !flush) begin
        underflow <= 1'b1;
      end else if (clr_err) begin
        underflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_fifo_v3.sv
// Directed bench for uart_fifo_v3: one standard-mode and one FWFT instance
// (DEPTH=16, AFULL=14, AEMPTY=2) sharing clock and reset.
module tb_uart_fifo_v3;

  logic       clk;
  logic       rst;
  int         total;
  int         bad;

  logic       s_flush, s_wr_en, s_rd_en, s_clr_err;
  logic [7:0] s_din, s_dout;
  logic       s_rd_valid, s_full, s_empty, s_afull, s_aempty, s_ovf, s_udf;
  logic [4:0] s_count;

  logic       f_flush, f_wr_en, f_rd_en, f_clr_err;
  logic [7:0] f_din, f_dout;
  logic       f_rd_valid, f_full, f_empty, f_afull, f_aempty, f_ovf, f_udf;
  logic [4:0] f_count;

  uart_fifo_v3 #(
    .DATA_WIDTH(8), .DEPTH(16), .AFULL_THRESH(14), .AEMPTY_THRESH(2), .FWFT(0)
  ) dut_std (
    .clk(clk), .rst(rst), .flush(s_flush), .din(s_din), .wr_en(s_wr_en), .rd_en(s_rd_en),
    .dout(s_dout), .rd_valid(s_rd_valid), .full(s_full), .empty(s_empty),
    .almost_full(s_afull), .almost_empty(s_aempty), .count(s_count),
    .overflow(s_ovf), .underflow(s_udf), .clr_err(s_clr_err)
  );

  uart_fifo_v3 #(
    .DATA_WIDTH(8), .DEPTH(16), .AFULL_THRESH(14), .AEMPTY_THRESH(2), .FWFT(1)
  ) dut_fwft (
    .clk(clk), .rst(rst), .flush(f_flush), .din(f_din), .wr_en(f_wr_en), .rd_en(f_rd_en),
    .dout(f_dout), .rd_valid(f_rd_valid), .full(f_full), .empty(f_empty),
    .almost_full(f_afull), .almost_empty(f_aempty), .count(f_count),
    .overflow(f_ovf), .underflow(f_udf), .clr_err(f_clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    s_flush = 0; s_wr_en = 0; s_rd_en = 0; s_clr_err = 0; s_din = 8'h00;
    f_flush = 0; f_wr_en = 0; f_rd_en = 0; f_clr_err = 0; f_din = 8'h00;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    total++;
    if ({s_dout, s_rd_valid, s_empty, s_full, s_afull, s_aempty, s_count, s_ovf, s_udf}
        !== {8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0}) begin
      bad++;
      $display("[TB] FAIL reset_std got dout=%h v=%b e=%b f=%b af=%b ae=%b cnt=%0d ov=%b un=%b exp 00 0 1 0 0 1 0 0 0",
               s_dout, s_rd_valid, s_empty, s_full, s_afull, s_aempty, s_count, s_ovf, s_udf);
    end
    total++;
    if ({f_dout, f_rd_valid, f_empty, f_count} !== {8'h00, 1'b0, 1'b1, 5'd0}) begin
      bad++;
      $display("[TB] FAIL reset_fwft got dout=%h v=%b e=%b cnt=%0d exp 00 0 1 0",
               f_dout, f_rd_valid, f_empty, f_count);
    end
  endtask

  task automatic test_basic();
    for (int i = 0; i < 4; i++) begin
      s_wr_en = 1; s_din = 8'(8'h10 + i);
      tick();
      total++;
      if ({s_empty, s_count} !== {1'b0, 5'(i + 1)}) begin
        bad++;
        $display("[TB] FAIL basic_write%0d got e=%b cnt=%0d exp e=0 cnt=%0d", i, s_empty, s_count, i + 1);
      end
    end
    s_wr_en = 0; s_rd_en = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if ({s_rd_valid, s_dout} !== {1'b1, 8'(8'h10 + i)}) begin
        bad++;
        $display("[TB] FAIL basic_read%0d got v=%b dout=%h exp v=1 dout=%h", i, s_rd_valid, s_dout, 8'(8'h10 + i));
      end
    end
    tick();
    s_rd_en = 0;
    total++;
    if ({s_rd_valid, s_udf, s_empty, s_count, s_dout} !== {1'b0, 1'b1, 1'b1, 5'd0, 8'h13}) begin
      bad++;
      $display("[TB] FAIL basic_underflow got v=%b un=%b e=%b cnt=%0d dout=%h exp v=0 un=1 e=1 cnt=0 dout=13",
               s_rd_valid, s_udf, s_empty, s_count, s_dout);
    end
    s_clr_err = 1;
    tick();
    s_clr_err = 0;
    total++;
    if (s_udf !== 1'b0) begin
      bad++;
      $display("[TB] FAIL basic_clr_underflow got un=%b exp un=0", s_udf);
    end
  endtask

  task automatic test_fill_wrap();
    logic [7:0] exp_q [$];
    for (int i = 0; i < 16; i++) begin
      s_wr_en = 1; s_din = 8'(8'hA0 + i);
      tick();
      if (i == 2 || i == 12 || i == 13 || i == 14 || i == 15) begin
        total++;
        if ({s_aempty, s_afull, s_full} !== {1'b0, (i >= 13), (i == 15)}) begin
          bad++;
          $display("[TB] FAIL fill_flags%0d got ae=%b af=%b f=%b exp ae=0 af=%b f=%b",
                   i, s_aempty, s_afull, s_full, (i >= 13), (i == 15));
        end
      end
    end
    total++;
    if (s_count !== 5'd16) begin
      bad++;
      $display("[TB] FAIL fill_count got %0d exp 16", s_count);
    end
    s_din = 8'h11;
    tick();
    s_wr_en = 0;
    total++;
    if ({s_ovf, s_count, s_full} !== {1'b1, 5'd16, 1'b1}) begin
      bad++;
      $display("[TB] FAIL fill_overflow got ov=%b cnt=%0d f=%b exp ov=1 cnt=16 f=1", s_ovf, s_count, s_full);
    end
    s_clr_err = 1;
    tick();
    s_clr_err = 0;
    s_rd_en = 1;
    for (int i = 0; i < 8; i++) begin
      tick();
      total++;
      if ({s_rd_valid, s_dout, s_full} !== {1'b1, 8'(8'hA0 + i), 1'b0}) begin
        bad++;
        $display("[TB] FAIL wrap_first_read%0d got v=%b dout=%h f=%b exp v=1 dout=%h f=0",
                 i, s_rd_valid, s_dout, s_full, 8'(8'hA0 + i));
      end
    end
    s_rd_en = 0;
    for (int i = 0; i < 8; i++) begin
      s_wr_en = 1; s_din = 8'(8'hB0 + i);
      tick();
    end
    s_wr_en = 0;
    for (int i = 0; i < 8; i++) exp_q.push_back(8'(8'hA8 + i));
    for (int i = 0; i < 8; i++) exp_q.push_back(8'(8'hB0 + i));
    s_rd_en = 1;
    for (int i = 0; i < 16; i++) begin
      tick();
      total++;
      if ({s_rd_valid, s_dout} !== {1'b1, exp_q[i]}) begin
        bad++;
        $display("[TB] FAIL wrap_drain%0d got v=%b dout=%h exp v=1 dout=%h", i, s_rd_valid, s_dout, exp_q[i]);
      end
    end
    s_rd_en = 0;
    tick();
    total++;
    if ({s_empty, s_count, s_ovf, s_udf} !== {1'b1, 5'd0, 1'b0, 1'b0}) begin
      bad++;
      $display("[TB] FAIL wrap_end got e=%b cnt=%0d ov=%b un=%b exp e=1 cnt=0 ov=0 un=0",
               s_empty, s_count, s_ovf, s_udf);
    end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 16; i++) begin
      s_wr_en = 1; s_din = 8'(8'hC0 + i);
      tick();
    end
    s_rd_en = 1; s_din = 8'hEE;
    tick();
    total++;
    if ({s_ovf, s_count, s_full, s_rd_valid, s_dout} !== {1'b1, 5'd15, 1'b0, 1'b1, 8'hC0}) begin
      bad++;
      $display("[TB] FAIL simul_full got ov=%b cnt=%0d f=%b v=%b dout=%h exp ov=1 cnt=15 f=0 v=1 dout=c0",
               s_ovf, s_count, s_full, s_rd_valid, s_dout);
    end
    s_wr_en = 0;
    for (int i = 1; i < 16; i++) begin
      tick();
      total++;
      if (s_dout !== 8'(8'hC0 + i)) begin
        bad++;
        $display("[TB] FAIL simul_drain%0d got dout=%h exp %h", i, s_dout, 8'(8'hC0 + i));
      end
    end
    s_rd_en = 0; s_clr_err = 1;
    tick();
    s_clr_err = 0;
    s_wr_en = 1; s_rd_en = 1; s_din = 8'h77;
    tick();
    s_wr_en = 0; s_rd_en = 0;
    total++;
    if ({s_udf, s_count, s_empty, s_rd_valid, s_ovf} !== {1'b1, 5'd1, 1'b0, 1'b0, 1'b0}) begin
      bad++;
      $display("[TB] FAIL simul_empty got un=%b cnt=%0d e=%b v=%b ov=%b exp un=1 cnt=1 e=0 v=0 ov=0",
               s_udf, s_count, s_empty, s_rd_valid, s_ovf);
    end
    s_rd_en = 1; s_clr_err = 1;
    tick();
    s_rd_en = 0; s_clr_err = 0;
    total++;
    if ({s_rd_valid, s_dout, s_count, s_udf} !== {1'b1, 8'h77, 5'd0, 1'b0}) begin
      bad++;
      $display("[TB] FAIL simul_readback got v=%b dout=%h cnt=%0d un=%b exp v=1 dout=77 cnt=0 un=0",
               s_rd_valid, s_dout, s_count, s_udf);
    end
  endtask

  task automatic test_flush_clr();
    for (int i = 0; i < 17; i++) begin
      s_wr_en = 1; s_din = 8'(8'hD0 + i);
      tick();
    end
    s_wr_en = 0; s_rd_en = 1;
    repeat (7) tick();
    s_rd_en = 0;
    total++;
    if ({s_count, s_ovf, s_dout} !== {5'd9, 1'b1, 8'hD6}) begin
      bad++;
      $display("[TB] FAIL flush_setup got cnt=%0d ov=%b dout=%h exp cnt=9 ov=1 dout=d6", s_count, s_ovf, s_dout);
    end
    s_flush = 1; s_wr_en = 1; s_rd_en = 1; s_din = 8'h99;
    tick();
    s_flush = 0; s_wr_en = 0; s_rd_en = 0;
    total++;
    if ({s_count, s_empty, s_full, s_rd_valid, s_ovf, s_udf, s_dout, s_aempty}
        !== {5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'hD6, 1'b1}) begin
      bad++;
      $display("[TB] FAIL flush got cnt=%0d e=%b f=%b v=%b ov=%b un=%b dout=%h ae=%b exp 0 1 0 0 1 0 d6 1",
               s_count, s_empty, s_full, s_rd_valid, s_ovf, s_udf, s_dout, s_aempty);
    end
    s_clr_err = 1;
    tick();
    s_clr_err = 0;
    total++;
    if (s_ovf !== 1'b0) begin
      bad++;
      $display("[TB] FAIL clr_overflow got ov=%b exp ov=0", s_ovf);
    end
  endtask

  task automatic test_fwft();
    f_wr_en = 1; f_din = 8'h55;
    tick();
    f_wr_en = 0;
    total++;
    if ({f_rd_valid, f_empty, f_count} !== {1'b0, 1'b1, 5'd1}) begin
      bad++;
      $display("[TB] FAIL fwft_edge_n got v=%b e=%b cnt=%0d exp v=0 e=1 cnt=1", f_rd_valid, f_empty, f_count);
    end
    tick();
    total++;
    if ({f_rd_valid, f_dout, f_empty, f_count} !== {1'b1, 8'h55, 1'b0, 5'd1}) begin
      bad++;
      $display("[TB] FAIL fwft_edge_n1 got v=%b dout=%h e=%b cnt=%0d exp v=1 dout=55 e=0 cnt=1",
               f_rd_valid, f_dout, f_empty, f_count);
    end
    for (int i = 0; i < 4; i++) begin
      f_wr_en = 1; f_din = 8'(8'h60 + i);
      tick();
    end
    f_wr_en = 0; f_rd_en = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if ({f_rd_valid, f_dout, f_count} !== {1'b1, 8'(8'h60 + i), 5'(4 - i)}) begin
        bad++;
        $display("[TB] FAIL fwft_stream%0d got v=%b dout=%h cnt=%0d exp v=1 dout=%h cnt=%0d",
                 i, f_rd_valid, f_dout, f_count, 8'(8'h60 + i), 4 - i);
      end
    end
    tick();
    f_rd_en = 0;
    total++;
    if ({f_rd_valid, f_empty, f_count, f_udf} !== {1'b0, 1'b1, 5'd0, 1'b0}) begin
      bad++;
      $display("[TB] FAIL fwft_drained got v=%b e=%b cnt=%0d un=%b exp v=0 e=1 cnt=0 un=0",
               f_rd_valid, f_empty, f_count, f_udf);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) begin
      s_wr_en = 1; s_din = 8'(8'h31 + i);
      tick();
    end
    s_din = 8'h34; s_rd_en = 1;
    tick();
    total++;
    if ({s_rd_valid, s_dout, s_count} !== {1'b1, 8'h31, 5'd3}) begin
      bad++;
      $display("[TB] FAIL async_setup got v=%b dout=%h cnt=%0d exp v=1 dout=31 cnt=3", s_rd_valid, s_dout, s_count);
    end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({s_dout, s_rd_valid, s_empty, s_full, s_afull, s_aempty, s_count, s_ovf, s_udf}
        !== {8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0}) begin
      bad++;
      $display("[TB] FAIL async_reset got dout=%h v=%b e=%b f=%b af=%b ae=%b cnt=%0d ov=%b un=%b exp 00 0 1 0 0 1 0 0 0",
               s_dout, s_rd_valid, s_empty, s_full, s_afull, s_aempty, s_count, s_ovf, s_udf);
    end
    idle_inputs();
    rst = 1'b0;
    tick();
    total++;
    if ({s_count, s_empty, s_rd_valid} !== {5'd0, 1'b1, 1'b0}) begin
      bad++;
      $display("[TB] FAIL async_after got cnt=%0d e=%b v=%b exp cnt=0 e=1 v=0", s_count, s_empty, s_rd_valid);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    idle_inputs();
    test_reset();
    test_basic();
    test_fill_wrap();
    test_simultaneous();
    test_flush_clr();
    test_fwft();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_fifo_v3.md
# uart_fifo_v3

Single-clock, parametrised synchronous FIFO succeeding the UART dual-clock FIFO, for buffering UART TX/RX bytes inside one clock domain. It adds configurable width/depth, a selectable first-word-fall-through (FWFT) read mode, programmable almost-full/almost-empty flags, an occupancy count, sticky overflow/underflow error flags and a synchronous flush. It sits between the UART byte engines and the host-side register/stream logic.

## Interface
- DATA_WIDTH, 8, word width in bits
- DEPTH, 2048, capacity in words; power of two, minimum 4
- AFULL_THRESH, DEPTH-4, almost_full asserts when count >= this value
- AEMPTY_THRESH, 4, almost_empty asserts when count <= this value
- FWFT, 0, 0 = standard registered read, 1 = first-word-fall-through
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  synchronous clear of contents, pointers and count
- din  in  DATA_WIDTH  write data
- wr_en  in  1  write request
- rd_en  in  1  read request (FWFT: pop/acknowledge the head word)
- dout  out  DATA_WIDTH  read data
- rd_valid  out  1  standard: dout updated this cycle; FWFT: dout holds a valid head word
- full  out  1  count == DEPTH
- empty  out  1  no word readable
- almost_full  out  1  count >= AFULL_THRESH
- almost_empty  out  1  count <= AEMPTY_THRESH
- count  out  $clog2(DEPTH)+1  words held, including the FWFT output register
- overflow  out  1  sticky: wr_en while full
- underflow  out  1  sticky: rd_en while empty
- clr_err  in  1  clears overflow/underflow

## Operation
- Storage: DEPTH-entry memory, read/write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH. count is the authoritative occupancy. Total capacity is DEPTH words in both modes.
- Write accepted iff wr_en && !full && !flush. Read accepted iff rd_en && !empty && !flush.
- Full/empty gating uses the current registered flags only:
  - a write while full is rejected even if a read is accepted in the same cycle;
  - a read while empty is rejected even if a write is accepted in the same cycle.
- Simultaneous accepted write and read: count unchanged, both pointers advance.
- Standard mode (FWFT=0):
  - an accepted read registers mem[rd_ptr] into dout and pulses rd_valid for one cycle;
  - otherwise dout holds its value and rd_valid=0;
  - empty = (count==0).
- FWFT mode (FWFT=1):
  - an internal output register prefetches the head word whenever it is empty and memory holds data;
  - rd_valid=1 while it holds a word, and empty = !rd_valid;
  - an accepted rd_en consumes the word, and the register refills in the same edge if memory holds data, giving back-to-back pops with no bubble.
- Flags and count are registered and update on the same edge as the accepted operation.
- Error flags:
  - overflow is set by wr_en && full, underflow by rd_en && empty (neither set during flush);
  - both clear only on clr_err or rst; set has priority over clr_err in the same cycle.
- flush (priority over wr_en/rd_en):
  - pointers and count go to 0, empty=1, full=0, rd_valid=0 (the FWFT output register is invalidated);
  - dout and the error flags are unchanged.
- Reset values: dout=0, rd_valid=0, empty=1, full=0, almost_full=0, almost_empty=1, count=0, overflow=0, underflow=0, pointers=0. Reset mid-operation discards all contents immediately.

## Timing
- Standard: write accepted at edge N → empty=0, count=1 after N. rd_en accepted at edge M → dout/rd_valid valid after M. Read latency is 1 cycle.
- FWFT: write into an empty FIFO at edge N → dout/rd_valid valid and empty=0 after N+1. Pop at edge M → the next word is visible after M if one is available.
- full asserts after the edge that accepts the DEPTH-th word. It deasserts after the first accepted read.
- Throughput: one write and one read per cycle, sustained.

## Test plan
- Reset/basic (DEPTH=16, FWFT=0): after rst, write 0x10..0x13, then rd_en for 5 cycles → dout 0x10,0x11,0x12,0x13 with rd_valid pulses. The 5th read is rejected: underflow=1, empty=1, count=0.
- Fill/wrap (DEPTH=16, AFULL=14, AEMPTY=2):
  - write 16 words 0xA0..0xAF → almost_full after the 14th, full after the 16th, count=16;
  - a 17th write of 0x11 → overflow=1, data not stored;
  - read 8, write 8 (pointer wrap), read all → 0xA8..0xAF then the new words, in order.
- Simultaneous: with count=16, wr_en+rd_en → write rejected, overflow=1, count=15. With count=0, wr_en+rd_en → read rejected, underflow=1, count=1.
- FWFT (FWFT=1): write 0x55 at edge N → rd_val=1, dout=0x55 after N+1. Stream 4 words with rd_en held high → one pop per cycle, no bubbles.
- Flush/clr_err: with count=9 and overflow=1, pulse flush → count=0, empty=1, overflow remains 1. Pulse clr_err → overflow=0.
- Async reset mid-stream: assert rst between clock edges while writing → all outputs take reset values immediately, without waiting for a clock edge.
